// File: rtl/lenet_pkg.sv
// Shared defaults and state encoding for the LeNet streaming front end.
package lenet_pkg;

    localparam int IMG_W_DEF      = 32;
    localparam int IMG_H_DEF      = 32;
    localparam int K_DEF          = 5;
    localparam int PIXELWIDTH_DEF = 8;

    // Window generator control states
    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_ACTIVE = 1'b1
    } win_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_generator_if.sv
// Pixel stream in, K x K window stream out.
interface window_generator_if #(
    parameter int K          = lenet_pkg::K_DEF,
    parameter int PIXELWIDTH = lenet_pkg::PIXELWIDTH_DEF
);
    logic [PIXELWIDTH-1:0]     pixel_in;
    logic                      pixel_valid;
    logic [K*K*PIXELWIDTH-1:0] window;
    logic                      window_valid;
    logic                      frame_done;

    // Upstream image reader / downstream consumer side
    modport master (
        output pixel_in,
        output pixel_valid,
        input  window,
        input  window_valid,
        input  frame_done
    );

    // Window generator side
    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output window,
        output window_valid,
        output frame_done
    );
endinterface

// File: rtl/line_buffer.sv
// Fixed delay line of DEPTH enabled samples: a (DEPTH-1)-entry circular RAM
// followed by the registered read port, so the output presented before an
// enabled edge is the sample written DEPTH enables earlier.
module line_buffer
    import lenet_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam int MEM_D = DEPTH - 1;
    localparam int PTR_W = cnt_width(MEM_D);

    logic [WIDTH-1:0] r_mem [MEM_D];
    logic [PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_dout;

    // Circular read/write pointer advances once per enabled sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PTR_W'(MEM_D - 1)) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    // Read-before-write on the same slot; contents are not cleared
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_dout       <= r_mem[r_ptr];
            r_mem[r_ptr] <= i_data;
        end
    end

    assign o_data = r_dout;

endmodule

// File: rtl/window_generator.sv
// Sliding K x K window over a raster-order pixel stream. K-1 line buffers
// provide the older rows; a K x K register array shifts left on each
// accepted pixel, and a FILL/ACTIVE controller flags fully in-image windows.
module window_generator
    import lenet_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int K          = K_DEF,
    parameter int PIXELWIDTH = PIXELWIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    window_generator_if.slave  bus
);
    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_win_fire;
    logic                  w_frame_last;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    win_state_e            r_state;
    win_state_e            w_state_next;

    logic [PIXELWIDTH-1:0] w_lb_in  [K-1];
    logic [PIXELWIDTH-1:0] w_lb_out [K-1];
    logic [PIXELWIDTH-1:0] w_col_in [K];
    logic [PIXELWIDTH-1:0] r_win    [K][K];

    logic [K*K*PIXELWIDTH-1:0] w_window_flat;
    logic                      r_window_valid;
    logic                      r_frame_done;

    // Pixels offered while reset is held are dropped
    assign w_accept   = rst && bus.pixel_valid;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));

    // Line buffers are chained: buffer 0 sees the live pixel, buffer i the
    // output of buffer i-1
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            w_lb_in[i] = '0;
        end
        w_lb_in[0] = bus.pixel_in;
        for (int i = 1; i < K - 1; i++) begin
            w_lb_in[i] = w_lb_out[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
            line_buffer #(
                .DEPTH (IMG_W),
                .WIDTH (PIXELWIDTH)
            ) u_line_buffer (
                .clk    (clk),
                .rst    (rst),
                .i_en   (w_accept),
                .i_data (w_lb_in[gi]),
                .o_data (w_lb_out[gi])
            );
        end
    endgenerate

    // New right-hand column: oldest row at the top, live pixel at the bottom
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            w_col_in[r] = w_lb_out[K-2-r];
        end
        w_col_in[K-1] = bus.pixel_in;
    end

    // Window register: shift every row left, load the new column at K-1
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_col_in[r];
            end
        end
    end

    // Raster position of the pixel currently being accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Controller next state: ACTIVE from the first pixel of row K-1 until
    // the last pixel of the frame
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && (r_row == RW'(K - 1))) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_accept && w_col_last && w_row_last) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    // Controller outputs: a window completes once K columns of an active
    // row have been shifted in, so row boundaries are never straddled
    always_comb begin
        w_win_fire   = w_accept && (r_state == ST_ACTIVE) && (r_col >= CW'(K - 1));
        w_frame_last = w_accept && w_col_last && w_row_last;
    end

    // Registered status flags, one cycle after the triggering pixel
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= w_win_fire;
            r_frame_done   <= w_frame_last;
        end
    end

    // Flatten the window: element (r,c) at [(r*K+c)*PIXELWIDTH +: PIXELWIDTH]
    always_comb begin
        w_window_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_window_flat[(r*K+c)*PIXELWIDTH +: PIXELWIDTH] = r_win[r][c];
            end
        end
    end

    assign bus.window       = w_window_flat;
    assign bus.window_valid = r_window_valid;
    assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: the driver pushes the expected
// window for every accepted pixel that completes one; a negedge monitor pops.
module tb_window_generator;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int KK   = 5;
    localparam int PW   = 8;
    localparam int NWIN = (H - KK + 1) * (W - KK + 1);

    typedef struct {
        logic [KK*KK*PW-1:0] win;
        bit                  last;
        int                  idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    window_generator_if #(.K(KK), .PIXELWIDTH(PW)) bus ();

    window_generator #(
        .IMG_W      (W),
        .IMG_H      (H),
        .K          (KK),
        .PIXELWIDTH (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks      = 0;
    int         errors      = 0;
    logic [PW-1:0] img [H][W];
    int         drv_idx     = 0;
    int         acc_count   = 0;
    bit         prev_acc    = 1'b0;
    int         mon_windows = 0;
    int         mon_frames  = 0;

    // Reference: element (i,j) of the window ending at (r,c)
    function automatic logic [KK*KK*PW-1:0] model_window(input int r, input int c);
        logic [KK*KK*PW-1:0] w;
        w = '0;
        for (int i = 0; i < KK; i++) begin
            for (int j = 0; j < KK; j++) begin
                w[(i*KK+j)*PW +: PW] = img[r-KK+1+i][c-KK+1+j];
            end
        end
        return w;
    endfunction

    task automatic make_image(input bit ramp);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img[r][c] = ramp ? PW'((r * 32 + c) & 255) : PW'($urandom);
            end
        end
    endtask

    // Record what the DUT accepted on each edge
    always @(posedge clk) begin
        prev_acc = (rst === 1'b1) && (bus.pixel_valid === 1'b1);
        if (prev_acc) acc_count++;
    end

    // Monitor: compare every presented window against the scoreboard
    always @(negedge clk) begin
        if (bus.window_valid === 1'b1) begin
            mon_windows++;
            if (bus.frame_done === 1'b1) mon_frames++;
            checks++;
            if (!prev_acc) begin
                errors++;
                $display("FAIL valid_after_idle: window_valid=1 with no pixel accepted on previous edge, required 0");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window: got window %h at pixel %0d, required no window", bus.window, acc_count);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (bus.window !== mon_e.win) begin
                    errors++;
                    $display("FAIL window_data: got %h, required %h (pixel %0d)", bus.window, mon_e.win, mon_e.idx);
                end
                checks++;
                if (bus.frame_done !== mon_e.last) begin
                    errors++;
                    $display("FAIL frame_done: got %0b, required %0b (pixel %0d)", bus.frame_done, mon_e.last, mon_e.idx);
                end
                checks++;
                if (acc_count != mon_e.idx) begin
                    errors++;
                    $display("FAIL latency: window after pixel %0d, required after pixel %0d", acc_count, mon_e.idx);
                end
                $display("window #%0d after pixel %0d frame_done=%0b", mon_windows, acc_count, bus.frame_done);
            end
        end else if (bus.frame_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_alone: frame_done=1 with window_valid=0, required 0");
        end
    end

    // Drive npix pixels of img in raster order; valid_pct sets the duty cycle
    task automatic send_frame(input int npix, input int valid_pct);
        exp_t e;
        for (int p = 0; p < npix; p++) begin
            int r = p / W;
            int c = p % W;
            while (int'($urandom_range(99)) >= valid_pct) begin
                bus.pixel_valid = 1'b0;
                bus.pixel_in    = PW'($urandom);
                @(posedge clk);
                #1;
            end
            bus.pixel_valid = 1'b1;
            bus.pixel_in    = img[r][c];
            @(posedge clk);
            drv_idx++;
            if (r >= KK - 1 && c >= KK - 1) begin
                e.win  = model_window(r, c);
                e.last = (r == H - 1) && (c == W - 1);
                e.idx  = drv_idx;
                exp_q.push_back(e);
            end
            #1;
        end
    endtask

    task automatic idle(input int n);
        bus.pixel_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset with pixel_valid high (must be ignored), then check outputs
    task automatic do_reset(input int cycles);
        rst             = 1'b0;
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = PW'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        rst             = 1'b1;
        bus.pixel_valid = 1'b0;
        checks++;
        if (bus.window_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: window_valid=%0b, required 0", bus.window_valid);
        end
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done: frame_done=%0b, required 0", bus.frame_done);
        end
        checks++;
        if (bus.window !== '0) begin
            errors++;
            $display("FAIL reset_window: window=%h, required 0", bus.window);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pending: %0d windows outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        $display("reset released after %0d cycles", cycles);
    endtask

    task automatic check_counts(input string name, input int win0, input int fr0, input int nframes);
        idle(4);
        checks++;
        if (mon_windows - win0 != nframes * NWIN) begin
            errors++;
            $display("FAIL %s_windows: got %0d, required %0d", name, mon_windows - win0, nframes * NWIN);
        end
        checks++;
        if (mon_frames - fr0 != nframes) begin
            errors++;
            $display("FAIL %s_frames: got %0d, required %0d", name, mon_frames - fr0, nframes);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d windows never presented, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int w0, f0;
        rst             = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        do_reset(3);

        // Ramp image, continuous valid
        w0 = mon_windows; f0 = mon_frames;
        make_image(1'b1);
        send_frame(W * H, 100);
        check_counts("ramp", w0, f0, 1);

        // Ramp image, ~50% valid
        w0 = mon_windows; f0 = mon_frames;
        make_image(1'b1);
        send_frame(W * H, 50);
        check_counts("gapped", w0, f0, 1);

        // Back-to-back frames: ramp then random, no idle between
        w0 = mon_windows; f0 = mon_frames;
        make_image(1'b1);
        send_frame(W * H, 100);
        make_image(1'b0);
        send_frame(W * H, 100);
        check_counts("b2b", w0, f0, 2);

        // Abandon a frame after 500 pixels, then a fresh ramp frame
        make_image(1'b0);
        send_frame(500, 100);
        do_reset(1);
        w0 = mon_windows; f0 = mon_frames;
        make_image(1'b1);
        send_frame(W * H, 100);
        check_counts("midreset", w0, f0, 1);

        // Random image, random gaps
        w0 = mon_windows; f0 = mon_frames;
        make_image(1'b0);
        send_frame(W * H, 70);
        check_counts("random", w0, f0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter IMG_W, default 32: pixels per image row.
REQ-002 Parameter IMG_H, default 32: rows per image.
REQ-003 Parameter K, default 5: convolution kernel size (K x K window).
REQ-004 Parameter PIXELWIDTH, default 8: bits per pixel.
REQ-005 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 pixel_in  input  PIXELWIDTH  raster-order pixel from the upstream image reader.
REQ-008 pixel_valid  input  1  pixel_in is accepted on every rising edge where this is high.
REQ-009 window  output  K*K*PIXELWIDTH  flattened window; element (r,c) SHALL sit at bits [(r*K+c)*PIXELWIDTH +: PIXELWIDTH], with r=0 as the top (oldest) row and c=0 as the leftmost column.
REQ-010 window_valid  output  1  window holds a complete, fully in-image K x K neighbourhood.
REQ-011 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 The block SHALL hold K-1 line buffers, each IMG_W x PIXELWIDTH, that delay the stream by exactly one row per buffer.
REQ-013 The block SHALL hold a K x K register array; on each accepted pixel every row SHALL shift left by one column, and column K-1 SHALL load {line buffer K-2 output, ..., line buffer 0 output, pixel_in} for rows 0..K-1.
REQ-014 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL give the position of the pixel being accepted.
REQ-015 col SHALL advance only on accepted pixels; it SHALL wrap from IMG_W-1 to 0 and increment row.
REQ-016 row SHALL wrap from IMG_H-1 to 0 on the last pixel of a frame.
REQ-017 State machine FILL -> ACTIVE -> FILL.
REQ-018 FILL SHALL hold while row < K-1; the first accepted pixel of row K-1 SHALL move the state to ACTIVE.
REQ-019 The accepted pixel at (IMG_H-1, IMG_W-1) SHALL move the state from ACTIVE back to FILL.
REQ-020 window_valid SHALL be registered high in the cycle after a pixel accepted at row >= K-1 and col >= K-1; otherwise it SHALL be low.
REQ-021 Latency from accepting the bottom-right window pixel to window_valid SHALL be 1 cycle.
REQ-022 Windows SHALL never straddle a row boundary; the first K-1 accepted pixels of each row SHALL produce no window_valid.
REQ-023 A frame SHALL yield exactly (IMG_H-K+1)*(IMG_W-K+1) windows (784 with the defaults).
REQ-024 With pixel_valid low, the window register, counters and line buffers SHALL hold their values, and window_valid SHALL be low in the next cycle.
REQ-025 frame_done SHALL assert in the same cycle as the final window_valid of the frame.
REQ-026 Back-to-back frames SHALL need no idle cycles; the next frame's pixels SHALL be accepted immediately.
REQ-027 No arithmetic beyond the counters; pixel data SHALL pass through unmodified.

Reset
REQ-028 While rst=0 at a clock edge: col=0, row=0, state=FILL, window_valid=0, frame_done=0, window=0.
REQ-029 Line buffer contents need not be cleared; stale data SHALL never appear in a valid window.
REQ-030 A reset asserted mid-frame SHALL abandon that frame; the next accepted pixel after release SHALL be treated as (0,0).
REQ-031 pixel_valid SHALL be ignored while rst=0.

Structure
REQ-032 The defaults for IMG_W, IMG_H, K and PIXELWIDTH, plus the state encoding, SHALL live in the shared package lenet_pkg.
REQ-033 A single sub-module, line_buffer (parameters DEPTH and WIDTH, with shift-enable), SHALL be instantiated K-1 times.

Verification
REQ-034 Reset, then a ramp image pixel=(row*32+col)&0xFF with continuous valid -> first window_valid 1 cycle after pixel 133; element (0,0)=0x00, (2,2)=0x42, (4,4)=0x84.
REQ-035 Same ramp image -> exactly 784 window_valid pulses and one frame_done, coincident with the last window; the last window has element (4,4)=0xFF.
REQ-036 Ramp image with pixel_valid randomly low 50% of cycles -> an identical sequence of 784 windows, and no window_valid in a cycle following pixel_valid=0.
REQ-037 Two back-to-back frames -> frame_done after pixels 1024 and 2048; the second frame's first window follows pixel 1157, with element (0,0)=0x00.
REQ-038 rst=0 for one cycle after pixel 500, then a fresh frame -> no window_valid until 133 new pixels, and window contents match a clean frame.
REQ-039 Pixels accepted at col 0..3 of any row >= 4 -> window_valid stays low; the pixel at col 4 -> window_valid high next cycle.
